// File: rtl/lbl_ram_wr_sched_pkg.sv
// Shared widths, arbitration decode and helpers for the label RAM write scheduler.
package lbl_ram_wr_sched_pkg;

    // Label RAM geometry used by the VGA text pipeline.
    localparam int unsigned RAM_ADDR_W   = 8;
    localparam int unsigned RAM_DATA_W   = 8;
    localparam int unsigned STARVE_CNT_W = 16;

    // Per-cycle decision about who owns the RAM port.
    //   ARB_IDLE  : nobody needs the port
    //   ARB_READ  : pipeline reads, no write pending
    //   ARB_HOLD  : pipeline reads, a write waits behind it
    //   ARB_WRITE : write issues while the pipeline is idle
    //   ARB_FORCE : write issues over a pipeline read (read is stolen)
    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_READ  = 3'd1,
        ARB_HOLD  = 3'd2,
        ARB_WRITE = 3'd3,
        ARB_FORCE = 3'd4
    } arb_e;

    // Saturating increment: holds at lim once reached.
    function automatic logic [STARVE_CNT_W-1:0] sat_inc(
        input logic [STARVE_CNT_W-1:0] cnt,
        input logic [STARVE_CNT_W-1:0] lim
    );
        if (cnt == lim) begin
            return cnt;
        end
        return cnt + STARVE_CNT_W'(1);
    endfunction

endpackage

// File: rtl/lbl_ram_wr_sched_wr_queue.sv
// Small synchronous FIFO holding pending {addr, data} writes.
// Handshake: an entry is stored at a rising edge when push_valid_i and
// push_ready_o are both high; push_ready_o is registered and reflects the
// occupancy after that edge, so a full queue refuses pushes even while popping.
module lbl_ram_wr_sched_wr_queue
    import lbl_ram_wr_sched_pkg::*;
#(
    parameter int unsigned ENTRY_W  = 16,
    parameter int unsigned DEPTH_LG = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_valid_i,
    input  logic [ENTRY_W-1:0]  push_data_i,
    output logic                push_ready_o,
    input  logic                pop_i,
    output logic [ENTRY_W-1:0]  head_o,
    output logic [DEPTH_LG:0]   level_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LG;
    localparam logic [DEPTH_LG:0] FULL_LVL = {1'b1, {DEPTH_LG{1'b0}}};

    logic [ENTRY_W-1:0]  mem_q [DEPTH];
    logic [DEPTH_LG-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LG-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LG:0]   level_q, level_d;
    logic                ready_q, ready_d;
    logic                do_push;
    logic                do_pop;

    assign do_push = push_valid_i & ready_q;
    assign do_pop  = pop_i & (level_q != '0);

    // Next-state for pointers, occupancy and the registered ready.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LG'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LG'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (DEPTH_LG+1)'(1);
            2'b01:   level_d = level_q - (DEPTH_LG+1)'(1);
            default: level_d = level_q;
        endcase
        ready_d = (level_d != FULL_LVL);
    end

    // Control state; reset discards every queued entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    // Storage array; contents are only meaningful while level_q covers them.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o       = mem_q[rd_ptr_q];
    assign level_o      = level_q;
    assign push_ready_o = ready_q;

endmodule

// File: rtl/lbl_ram_wr_sched.sv
// Label RAM port arbiter: the render pipeline owns the port whenever it asks,
// queued writes take idle cycles, and a write that has waited STARVE_MAX
// blocked cycles is forced over a read, which is then flagged via rd_stolen.
// Write handshake: a request transfers at a rising edge of px_clk when
// wr_valid and wr_ready are both high; wr_addr/wr_data are sampled there.
module lbl_ram_wr_sched
    import lbl_ram_wr_sched_pkg::*;
#(
    parameter int unsigned ADDR_W     = RAM_ADDR_W,
    parameter int unsigned DATA_W     = RAM_DATA_W,
    parameter int unsigned DEPTH_LG   = 2,
    parameter int unsigned STARVE_MAX = 1023
) (
    input  logic              px_clk,
    input  logic              reset_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    output logic              rd_stolen,
    output logic [DEPTH_LG:0] level
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);
    localparam bit STARVE_EN = (STARVE_MAX != 0);

    logic [ENTRY_W-1:0]      head_entry;
    logic [ADDR_W-1:0]       head_addr;
    logic [DATA_W-1:0]       head_data;
    logic [DEPTH_LG:0]       q_level;
    logic                    pending;
    logic                    starve_hit;
    logic                    grant;
    arb_e                    arb_sel;
    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                    rd_stolen_q, rd_stolen_d;

    lbl_ram_wr_sched_wr_queue #(
        .ENTRY_W  (ENTRY_W),
        .DEPTH_LG (DEPTH_LG)
    ) u_wr_queue (
        .clk_i        (px_clk),
        .rst_ni       (reset_n),
        .push_valid_i (wr_valid),
        .push_data_i  ({wr_addr, wr_data}),
        .push_ready_o (wr_ready),
        .pop_i        (grant),
        .head_o       (head_entry),
        .level_o      (q_level)
    );

    assign head_addr  = head_entry[ENTRY_W-1:DATA_W];
    assign head_data  = head_entry[DATA_W-1:0];
    assign pending    = (q_level != '0);
    assign starve_hit = STARVE_EN && (starve_cnt_q == STARVE_LIM);

    // Decide who owns the RAM port this cycle.
    always_comb begin
        arb_sel = ARB_IDLE;
        if (pending) begin
            if (!rd_req) begin
                arb_sel = ARB_WRITE;
            end else if (starve_hit) begin
                arb_sel = ARB_FORCE;
            end else begin
                arb_sel = ARB_HOLD;
            end
        end else if (rd_req) begin
            arb_sel = ARB_READ;
        end
    end

    assign grant = (arb_sel == ARB_WRITE) || (arb_sel == ARB_FORCE);

    // RAM port mux: the head write on grant, otherwise the pipeline read address.
    always_comb begin
        ram_addr = rd_addr;
        ram_din  = '0;
        ram_we   = 1'b0;
        if (grant) begin
            ram_addr = head_addr;
            ram_din  = head_data;
            ram_we   = 1'b1;
        end
    end

    // Starvation counter and stolen-read flag next state.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        rd_stolen_d  = (arb_sel == ARB_FORCE);
        if (grant || !pending) begin
            starve_cnt_d = '0;
        end else if (rd_req) begin
            starve_cnt_d = sat_inc(starve_cnt_q, STARVE_LIM);
        end
    end

    // Registered arbitration state; rd_stolen lines up with the RAM's dout.
    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= '0;
            rd_stolen_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_stolen_q  <= rd_stolen_d;
        end
    end

    assign rd_stolen = rd_stolen_q;
    assign level     = q_level;

endmodule
